harvos_dmem_arb: RTL and testbench

HARVOS_DMEM_ARB -- requirements
Module: harvos_dmem_arb

---
 rtl/harvos_dmem_arb.sv | 127 ++++++++++++
 tb/tb_harvos_dmem_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harvos_dmem_arb.sv
// Two-master round-robin arbiter in front of a single-outstanding DMEM slave port.
// Define HARVOS_DMEM_ARB_TIMEOUT_EN to enable the WAIT timeout fault.
module harvos_dmem_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_fault,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_fault,

    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_fault
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("harvos_dmem_arb: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state;
    logic   owner;   // master that owns the outstanding access
    logic   prio;    // master that wins when both request

    logic   tmo;
    logic   arb;
    logic   gnt;
    logic   pick;
    logic   done;
    logic   cpl;

`ifdef HARVOS_DMEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt;

    assign tmo = !rst && (state == WAIT) && (tmo_cnt == TMO_LIMIT);
`else
    assign tmo = 1'b0;
`endif

    // A completing WAIT cycle doubles as an arbitration cycle; a timeout cycle never grants.
    always_comb begin
        arb  = !rst && !tmo && ((state == IDLE) || s_rvalid);
        pick = (m0_req && m1_req) ? prio : m1_req;
        gnt  = arb && (m0_req || m1_req);
        done = !rst && (state == WAIT) && s_rvalid && !tmo;
        cpl  = done || tmo;
    end

    always_comb begin
        m0_gnt  = gnt && !pick;
        m1_gnt  = gnt && pick;
        s_req   = gnt;
        s_we    = 1'b0;
        s_be    = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (gnt) begin
            s_we    = pick ? m1_we    : m0_we;
            s_be    = pick ? m1_be    : m0_be;
            s_addr  = pick ? m1_addr  : m0_addr;
            s_wdata = pick ? m1_wdata : m0_wdata;
        end
    end

    // Completions go to the owner only; data and fault stay zero unless rvalid is high.
    always_comb begin
        m0_rvalid = cpl && !owner;
        m1_rvalid = cpl && owner;
        m0_rdata  = (done && !owner) ? s_rdata : '0;
        m1_rdata  = (done && owner)  ? s_rdata : '0;
        m0_fault  = m0_rvalid && (done ? s_fault : 1'b1);
        m1_fault  = m1_rvalid && (done ? s_fault : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else if (gnt) begin
            state <= WAIT;
            owner <= pick;
            prio  <= !pick;
        end else if ((state == WAIT) && (s_rvalid || tmo)) begin
            state <= IDLE;
        end
    end

`ifdef HARVOS_DMEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || gnt) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT) && !s_rvalid && !tmo) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_harvos_dmem_arb.sv
// Scoreboard bench for harvos_dmem_arb: expected completions are queued as slave responses are driven.
module tb_harvos_dmem_arb;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_fault;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_fault;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_we, s_rvalid, s_fault;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    harvos_dmem_arb #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_fault(s_fault)
    );

    typedef struct packed {
        logic        m;
        logic [31:0] rdata;
        logic        fault;
    } cpl_t;

    cpl_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] d, input logic f);
        cpl_t e;
        e.m = m;
        e.rdata = d;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
        s_rvalid = 0; s_rdata = 0; s_fault = 0;
    endtask

    task automatic chk_gnt(input string tag, input logic g0, input logic g1,
                           input logic [31:0] addr, input logic we);
        check({tag, "_m0_gnt"}, m0_gnt, g0);
        check({tag, "_m1_gnt"}, m1_gnt, g1);
        check({tag, "_s_req"}, s_req, g0 | g1);
        check({tag, "_s_addr"}, s_addr, addr);
        check({tag, "_s_we"}, s_we, we);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_gnt(tag, 0, 0, 0, 0);
        check({tag, "_s_be"}, s_be, 0);
        check({tag, "_s_wdata"}, s_wdata, 0);
        check({tag, "_m0_rvalid"}, m0_rvalid, 0);
        check({tag, "_m1_rvalid"}, m1_rvalid, 0);
        check({tag, "_m0_rdata"}, m0_rdata, 0);
        check({tag, "_m1_rdata"}, m1_rdata, 0);
        check({tag, "_m0_fault"}, m0_fault, 0);
        check({tag, "_m1_fault"}, m1_fault, 0);
    endtask

    // Per-cycle protocol rules and scoreboard pop on every master completion.
    always @(negedge clk) begin
        cpl_t e;
        check("rv_both", m0_rvalid & m1_rvalid, 0);
        check("gnt_both", m0_gnt & m1_gnt, 0);
        check("m0_gnt_no_req", m0_gnt & ~m0_req, 0);
        check("m1_gnt_no_req", m1_gnt & ~m1_req, 0);
        if (!m0_rvalid) begin
            check("m0_idle_rdata", m0_rdata, 0);
            check("m0_idle_fault", m0_fault, 0);
        end
        if (!m1_rvalid) begin
            check("m1_idle_rdata", m1_rdata, 0);
            check("m1_idle_fault", m1_fault, 0);
        end
        if (m0_rvalid | m1_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rv_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rv_owner", m1_rvalid, e.m);
                check("rv_rdata", m1_rvalid ? m1_rdata : m0_rdata, e.rdata);
                check("rv_fault", m1_rvalid ? m1_fault : m0_fault, e.fault);
            end
        end
    end

    initial begin
        int n0;
        int n1;
        logic [31:0] ea;

        // Reset: everything quiet even with requests and a slave response present
        rst = 1;
        clr_inputs();
        m0_req = 1; m1_req = 1; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_all_zero("rst");
        cyc_end();
        clr_inputs();
        cyc_end();

        // Single m0 write, one-cycle slave
        rst = 0;
        m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h2000_0000; m0_wdata = 32'h1;
        @(negedge clk);
        chk_gnt("wr", 1, 0, 32'h2000_0000, 1);
        check("wr_s_be", s_be, 4'hF);
        check("wr_s_wdata", s_wdata, 32'h1);
        cyc_end();
        clr_inputs();
        s_rvalid = 1;
        push(0, 0, 0);
        @(negedge clk);
        check("wr_m0_rvalid", m0_rvalid, 1);
        chk_gnt("wr_idle", 0, 0, 0, 0);
        check("wr_idle_be", s_be, 0);
        check("wr_idle_wdata", s_wdata, 0);
        cyc_end();
        clr_inputs();

        // Both masters reading continuously after reset: strict alternation from m0
        rst = 1;
        cyc_end();
        rst = 0;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            m0_req = 1; m1_req = 1;
            m0_addr = 32'h100 + 32'(4 * n0);
            m1_addr = 32'h200 + 32'(4 * n1);
            if (k > 0) begin
                s_rvalid = 1;
                s_rdata = 32'hD000_0000 + 32'(k);
                push(((k - 1) % 2) == 1, 32'hD000_0000 + 32'(k), 0);
            end
            ea = (k % 2 == 1) ? 32'h200 + 32'(4 * n1) : 32'h100 + 32'(4 * n0);
            @(negedge clk);
            chk_gnt("rr", k % 2 == 0, k % 2 == 1, ea, 0);
            if (k % 2 == 1) n1++; else n0++;
            cyc_end();
        end
        clr_inputs();
        s_rvalid = 1; s_rdata = 32'hD000_0004;
        push(1, 32'hD000_0004, 0);
        @(negedge clk);
        chk_gnt("rr_end", 0, 0, 0, 0);
        cyc_end();
        clr_inputs();

        // m1 alone, back-to-back reads
        for (int k = 0; k < 4; k++) begin
            m1_req = (k < 3);
            m1_addr = (k < 3) ? 32'h10 + 32'(4 * k) : 32'h0;
            if (k > 0) begin
                s_rvalid = 1;
                s_rdata = 32'hA000_0000 + 32'(k);
                push(1, 32'hA000_0000 + 32'(k), 0);
            end
            @(negedge clk);
            chk_gnt("m1b2b", 0, k < 3, (k < 3) ? 32'h10 + 32'(4 * k) : 32'h0, 0);
            cyc_end();
        end
        clr_inputs();

        // Slave fault on an m1 read
        m1_req = 1; m1_addr = 32'h40;
        @(negedge clk);
        chk_gnt("flt", 0, 1, 32'h40, 0);
        cyc_end();
        clr_inputs();
        s_rvalid = 1; s_fault = 1; s_rdata = 32'hBAD0_0000;
        push(1, 32'hBAD0_0000, 1);
        @(negedge clk);
        check("flt_m1_fault", m1_fault, 1);
        check("flt_m0_rvalid", m0_rvalid, 0);
        cyc_end();
        clr_inputs();

        // Slow slave: m1 waits through m0's outstanding access, then wins
        m0_req = 1; m0_addr = 32'h50;
        @(negedge clk);
        chk_gnt("slow_g0", 1, 0, 32'h50, 0);
        cyc_end();
        clr_inputs();
        m1_req = 1; m1_addr = 32'h54;
        @(negedge clk);
        chk_gnt("slow_hold", 0, 0, 0, 0);
        cyc_end();
        s_rvalid = 1; s_rdata = 32'h5555_0000;
        push(0, 32'h5555_0000, 0);
        @(negedge clk);
        chk_gnt("slow_g1", 0, 1, 32'h54, 0);
        cyc_end();
        m1_req = 0; m1_addr = 0;
        s_rdata = 32'h5555_0001;
        push(1, 32'h5555_0001, 0);
        @(negedge clk);
        chk_gnt("slow_end", 0, 0, 0, 0);
        cyc_end();
        clr_inputs();

        // Stray slave response while idle must not reach either master
        s_rvalid = 1; s_rdata = 32'hFFFF_FFFF; s_fault = 1;
        @(negedge clk);
        check("stray_m0_rvalid", m0_rvalid, 0);
        check("stray_m1_rvalid", m1_rvalid, 0);
        cyc_end();
        clr_inputs();

`ifdef HARVOS_DMEM_ARB_TIMEOUT_EN
        // Silent slave: fault completion after four silent WAIT cycles, late response ignored
        m0_req = 1; m0_addr = 32'h60;
        @(negedge clk);
        chk_gnt("tmo_g", 1, 0, 32'h60, 0);
        cyc_end();
        clr_inputs();
        s_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tmo_wait_rvalid", m0_rvalid, 0);
            cyc_end();
        end
        m1_req = 1; m1_addr = 32'h70;
        push(0, 0, 1);
        @(negedge clk);
        check("tmo_m0_rvalid", m0_rvalid, 1);
        chk_gnt("tmo_nogrant", 0, 0, 0, 0);
        cyc_end();
        s_rvalid = 1; s_rdata = 32'h0000_1234;
        @(negedge clk);
        chk_gnt("tmo_late", 0, 1, 32'h70, 0);
        cyc_end();
        m1_req = 0; m1_addr = 0;
        s_rdata = 32'h7777_0000;
        push(1, 32'h7777_0000, 0);
        @(negedge clk);
        chk_gnt("tmo_end", 0, 0, 0, 0);
        cyc_end();
        clr_inputs();
`else
        // Silent slave: WAIT holds with no completion until the slave answers
        m0_req = 1; m0_addr = 32'h60;
        @(negedge clk);
        chk_gnt("nto_g", 1, 0, 32'h60, 0);
        cyc_end();
        clr_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("nto_wait_rvalid", m0_rvalid, 0);
            cyc_end();
        end
        s_rvalid = 1; s_rdata = 32'h7777_0000;
        push(0, 32'h7777_0000, 0);
        @(negedge clk);
        check("nto_m0_rvalid", m0_rvalid, 1);
        cyc_end();
        clr_inputs();
`endif

        // Reset mid-WAIT: access abandoned, priority back to m0
        m0_req = 1; m0_addr = 32'h80;
        @(negedge clk);
        chk_gnt("rw_g", 1, 0, 32'h80, 0);
        cyc_end();
        rst = 1;
        m0_req = 1; m1_req = 1; m0_addr = 32'h84; m1_addr = 32'h88;
        s_rvalid = 1; s_rdata = 32'hEEEE_EEEE;
        @(negedge clk);
        chk_all_zero("rw_rst");
        cyc_end();
        rst = 0;
        @(negedge clk);
        chk_gnt("rw_first", 1, 0, 32'h84, 0);
        cyc_end();
        m0_req = 0; m0_addr = 0;
        s_rdata = 32'h6666_0000;
        push(0, 32'h6666_0000, 0);
        @(negedge clk);
        chk_gnt("rw_second", 0, 1, 32'h88, 0);
        cyc_end();
        m1_req = 0; m1_addr = 0;
        s_rdata = 32'h6666_0001;
        push(1, 32'h6666_0001, 0);
        @(negedge clk);
        chk_gnt("rw_end", 0, 0, 0, 0);
        cyc_end();
        clr_inputs();
        cyc_end();
        cyc_end();

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
